fmap_row_writer: RTL and testbench
==================================

Name: fmap_row_writer

Overview:
- Write-side controller for the feature-map row buffer BRAM.
- Accepts a valid/ready stream of packed pixel words and writes them into a ring of row slots.
- Uses the same address map the row-window reader consumes: stride 8 pixels per word, 160 pixels per row.
- Tracks how many complete rows are buffered, asserts window_ready once three rows are available, and applies backpressure when all slots are occupied.

Parameters:
DATA_W, 64, width of one packed pixel word (8 pixels x 8 bit)
ADDR_W, 13, BRAM address width (pixel-granular)
PIX_PER_WORD, 8, address increment per word
ROW_STRIDE, 160, address distance between row slots
WORDS_PER_ROW, 20, words per feature-map row
FRAME_ROWS, 18, rows per frame
BUF_ROWS, 4, row slots in the ring buffer

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begins a frame, honoured only in IDLE
in_data  input  DATA_W  packed pixel word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
row_release  input  1  pulse from reader; oldest buffered row consumed
wr_en  output  1  BRAM write enable
wr_addr  output  ADDR_W  BRAM write address
wr_data  output  DATA_W  BRAM write data
rows_avail  output  3  complete rows buffered and not yet released
window_ready  output  1  rows_avail >= 3
count_row  output  6  frame row currently being written (0..FRAME_ROWS-1)
count_col  output  5  word index within current row (0..WORDS_PER_ROW-1)
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (synchronous): state=IDLE. in_ready, wr_en, wr_addr, wr_data, rows_avail, window_ready, count_row, count_col, busy and frame_done are all 0. Slot pointer is 0.
- Reset mid-operation aborts the frame, and any partial row is discarded.
- State IDLE:
  - in_ready=0.
  - start=1 -> FILL; counters, slot pointer and rows_avail are cleared.
- State FILL:
  - in_ready = (rows_avail < BUF_ROWS), combinational from registers.
  - An accept is in_valid && in_ready.
- On accept:
  - Next cycle: wr_en=1, wr_data=in_data, wr_addr=slot*ROW_STRIDE + count_col*PIX_PER_WORD.
  - Latency is exactly 1 cycle; wr_en=0 on cycles without an accept.
  - count_col increments.
  - At WORDS_PER_ROW-1, count_col wraps to 0, slot advances mod BUF_ROWS (3 -> 0), count_row increments, and rows_avail increments.
- Accepting the last word of row FRAME_ROWS-1 -> DRAIN.
- Address arithmetic uses incremental adders, with no multiplier. The maximum address is 3*160+19*8=632, so there is no overflow.
- State DRAIN:
  - in_ready=0.
  - Waits until rows_avail==0, then pulses frame_done for 1 cycle and returns to IDLE.
- row_release handling:
  - rows_avail decrements.
  - Ignored when rows_avail==0.
  - Accepted in any non-IDLE state.
- Simultaneous row completion and row_release in the same cycle: rows_avail unchanged.
- Backpressure:
  - When rows_avail==BUF_ROWS, in_ready=0 until a release.
  - in_ready reasserts the cycle after row_release.
  - in_valid held high while in_ready=0 is not consumed.
- window_ready and busy are combinational decodes of registered rows_avail and state.
- start outside IDLE is ignored.

Test Plan:
1. Reset, start, then 20 back-to-back valid words (data = index) -> wr_addr 0,8,...,152 on consecutive cycles, one cycle after each accept, with wr_data matching. Afterwards rows_avail=1 and count_row=1.
2. Stream 3 rows with no release -> the last write is at addr 472, and window_ready rises on the cycle after the accept of row 2 word 19.
3. Stream with no releases -> after 80 words rows_avail=4 and in_ready=0, and word 81 stalls. Pulse row_release -> in_ready=1 next cycle, and word 81 is written at addr 0 (slot wrap).
4. row_release coincides with the accept of a row's last word at rows_avail=2 -> rows_avail stays 2.
5. Full frame of 18 rows with a reader releasing one row each time window_ready is high -> DRAIN entered after word 359. Release the remaining rows -> frame_done is a one-cycle pulse when rows_avail hits 0, then busy=0.
6. Reset asserted at row 1, word 7 -> next cycle wr_en=0, in_ready=0, rows_avail=0, busy=0. A new start then writes its first word at addr 0.

Source files
------------

// File: rtl/fmap_row_writer.sv
// fmap_row_writer: write-side controller for the feature-map row buffer BRAM.
// Takes a valid/ready stream of packed pixel words and writes them into a ring
// of BUF_ROWS row slots, using the same address map the row-window reader uses.
// It counts the complete rows that are buffered, raises window_ready once three
// rows are available, and stalls the stream while every slot is occupied.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             begins a frame (honoured only in IDLE)
//   in_data/valid     input pixel word stream; in_ready gives the backpressure
//   row_release       reader has consumed the oldest buffered row
//   wr_en/addr/data   BRAM write port, one cycle after each accepted word
//   rows_avail        complete rows buffered and not yet released
//   window_ready      rows_avail >= 3
//   count_row/col     frame row and word index currently being written
//   busy, frame_done  activity flag and one-cycle end-of-frame pulse
module fmap_row_writer #(
    parameter int DATA_W        = 64,
    parameter int ADDR_W        = 13,
    parameter int PIX_PER_WORD  = 8,
    parameter int ROW_STRIDE    = 160,
    parameter int WORDS_PER_ROW = 20,
    parameter int FRAME_ROWS    = 18,
    parameter int BUF_ROWS      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              row_release,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        rows_avail,
    output logic              window_ready,
    output logic [5:0]        count_row,
    output logic [4:0]        count_col,
    output logic              busy,
    output logic              frame_done
);

    localparam int SLOT_W = (BUF_ROWS > 1) ? $clog2(BUF_ROWS) : 1;

    localparam logic [4:0]        LAST_COL  = 5'(WORDS_PER_ROW - 1);
    localparam logic [5:0]        LAST_ROW  = 6'(FRAME_ROWS - 1);
    localparam logic [2:0]        FULL      = 3'(BUF_ROWS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BUF_ROWS - 1);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(PIX_PER_WORD);
    localparam logic [ADDR_W-1:0] SLOT_STEP = ADDR_W'(ROW_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [SLOT_W-1:0] slot;
    // slot_base and col_off track slot*ROW_STRIDE and count_col*PIX_PER_WORD
    // incrementally, so the address path needs only one adder.
    logic [ADDR_W-1:0] slot_base;
    logic [ADDR_W-1:0] col_off;

    logic accept;
    logic row_end;
    logic row_inc;
    logic row_dec;

    assign in_ready     = (state == FILL) && (rows_avail < FULL);
    assign accept       = in_valid && in_ready;
    assign row_end      = (count_col == LAST_COL);
    assign row_inc      = accept && row_end;
    // A release is ignored in IDLE and when nothing is buffered.
    assign row_dec      = row_release && (state != IDLE) && (rows_avail != 3'd0);
    assign window_ready = (rows_avail >= 3'd3);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = FILL;
            end
            FILL: begin
                if (row_inc && (count_row == LAST_ROW)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (rows_avail == 3'd0) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rows_avail <= 3'd0;
            count_row  <= 6'd0;
            count_col  <= 5'd0;
            slot       <= '0;
            slot_base  <= '0;
            col_off    <= '0;
        end else begin
            state <= state_nx;
            wr_en <= accept;
            if (accept) begin
                wr_addr <= slot_base + col_off;
                wr_data <= in_data;
            end
            if ((state == IDLE) && start) begin
                rows_avail <= 3'd0;
                count_row  <= 6'd0;
                count_col  <= 5'd0;
                slot       <= '0;
                slot_base  <= '0;
                col_off    <= '0;
            end else begin
                if (accept) begin
                    if (row_end) begin
                        count_col <= 5'd0;
                        col_off   <= '0;
                        // The finished frame leaves the row counter at 0.
                        count_row <= (count_row == LAST_ROW) ? 6'd0
                                                             : count_row + 6'd1;
                        if (slot == LAST_SLOT) begin
                            slot      <= '0;
                            slot_base <= '0;
                        end else begin
                            slot      <= slot + 1'b1;
                            slot_base <= slot_base + SLOT_STEP;
                        end
                    end else begin
                        count_col <= count_col + 5'd1;
                        col_off   <= col_off + COL_STEP;
                    end
                end
                // A row that completes in the same cycle as a release
                // cancels it out.
                unique case (1'b1)
                    (row_inc && !row_dec): rows_avail <= rows_avail + 3'd1;
                    (row_dec && !row_inc): rows_avail <= rows_avail - 3'd1;
                    default:               rows_avail <= rows_avail;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmap_row_writer.sv
// Testbench for fmap_row_writer: a frame-level reference model predicts every
// BRAM write and the row-occupancy outputs; a monitor checks the writes.
module tb_fmap_row_writer;

    localparam int WPR    = 20;
    localparam int FR     = 18;
    localparam int NB     = 4;
    localparam int STRIDE = 160;
    localparam int PPW    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        row_release = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [63:0] wr_data;
    logic [2:0]  rows_avail;
    logic        window_ready;
    logic [5:0]  count_row;
    logic [4:0]  count_col;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    fmap_row_writer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .row_release  (row_release),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rows_avail   (rows_avail),
        .window_ready (window_ready),
        .count_row    (count_row),
        .count_col    (count_col),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    typedef struct {
        logic [12:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    wr_t sbq[$];
    wr_t mon_e;
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    // Reference model: 0 idle, 1 filling, 2 draining; words accepted this
    // frame and complete rows still held in the buffer.
    int m_state = 0;
    int m_avail = 0;
    int m_words = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(m_state == 1 && m_avail < NB));
        chk("rows_avail", 64'(rows_avail), 64'(m_avail));
        chk("window_ready", 64'(window_ready), 64'(m_avail >= 3));
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("frame_done", 64'(frame_done), 64'(m_state == 2 && m_avail == 0));
        if (m_state == 1) begin
            chk("count_col", 64'(count_col), 64'(m_words % WPR));
            chk("count_row", 64'(count_row), 64'(m_words / WPR));
        end
    endtask

    // One cycle: check the current outputs, drive the inputs for the next
    // rising edge, and advance the model across that edge.
    task automatic step(input logic v, input logic [63:0] d, input logic rel,
                        input logic st, input logic rst);
        wr_t e;
        int  row;
        int  col;
        bit  rl;
        @(negedge clk);
        check_outputs();
        in_valid    = v;
        in_data     = d;
        row_release = rel;
        start       = st;
        reset       = rst;
        if (rst) begin
            m_state = 0;
            m_avail = 0;
            m_words = 0;
        end else if (m_state == 0) begin
            if (st) begin
                m_state = 1;
                m_avail = 0;
                m_words = 0;
            end
        end else if (m_state == 1) begin
            rl = rel && (m_avail > 0);
            if (v && (m_avail < NB)) begin
                row    = m_words / WPR;
                col    = m_words % WPR;
                e.addr = 13'((row % NB) * STRIDE + col * PPW);
                e.data = d;
                e.cyc  = cyc + 1;
                sbq.push_back(e);
                m_words++;
                if (m_words % WPR == 0) m_avail++;
                if (m_words == WPR * FR) m_state = 2;
            end
            if (rl) m_avail--;
        end else begin
            if (m_avail == 0) m_state = 0;
            else if (rel) m_avail--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Write monitor: every BRAM write must match the oldest predicted write
    // and appear exactly one cycle after its accept.
    always @(posedge clk) begin
        #2;
        if (wr_en === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d at cycle %0d",
                         wr_addr, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                chk("wr_data", wr_data, mon_e.data);
                chk("wr_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_write addr=%0d required at cycle %0d",
                     sbq[0].addr, sbq[0].cyc);
            void'(sbq.pop_front());
        end
    end

    task automatic random_frame(input int vprob);
        bit rel;
        bit v;
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6000 && m_state != 0; i++) begin
            v   = ($urandom_range(0, 99) < vprob);
            rel = ($urandom_range(0, 7) == 0) ||
                  ((m_avail >= 3 || m_state == 2) && $urandom_range(0, 1) == 1);
            step(v, {$urandom, $urandom}, rel,
                 $urandom_range(0, 39) == 0, 1'b0);
        end
        if (m_state != 0) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=busy required=idle");
        end
        idle(2);
    endtask

    initial begin
        idle(0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_count_row", 64'(count_row), 64'd0);
        chk("reset_count_col", 64'(count_col), 64'd0);

        // First row, data = word index.
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        idle(1);

        // Two more rows without release: window_ready rises.
        for (int i = 20; i < 60; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        idle(1);

        // Fourth row fills the ring; word 80 stalls until a release.
        for (int i = 60; i < 80; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'd80, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'd80, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'd80, 1'b0, 1'b0, 1'b0);

        // Release coinciding with a row completion at rows_avail 2.
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 81; i < 99; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'd99, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Rest of the frame with random traffic, then drain to IDLE.
        for (int i = 0; i < 6000 && m_state != 0; i++) begin
            step($urandom_range(0, 9) < 7, {$urandom, $urandom},
                 (m_avail >= 3 || m_state == 2) && $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, 1'b0);
        end
        if (m_state != 0) begin
            checks++;
            failures++;
            $display("FAIL frame1_timeout actual=busy required=idle");
        end
        idle(2);

        random_frame(90);
        random_frame(40);

        // Reset at row 1, word 7 discards the partial frame.
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 27; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'd27, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_wr_addr", 64'(wr_addr), 64'd0);
        chk("abort_count_row", 64'(count_row), 64'd0);
        chk("abort_count_col", 64'(count_col), 64'd0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h0123_4567_89ab_cdef, 1'b0, 1'b0, 1'b0);
        idle(3);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_queue actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
